// File: rtl/conv_pkg.sv
// Shared geometry constants for the convolution front end (padding stage and
// window generator), plus the padded-dimension derivation both stages use.
package conv_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int IMAGE_WIDTH  = 6;
    localparam int IMAGE_HEIGHT = 6;
    localparam int PADDING      = 1;
    localparam int CHANNEL_NUM  = 2;
    localparam int KERNEL       = 3;

    // Size of one image dimension once the border has been inserted
    function automatic int padded_dim(input int dim, input int pad);
        return dim + 2 * pad;
    endfunction

    localparam int PW = padded_dim(IMAGE_WIDTH, PADDING);
    localparam int PH = padded_dim(IMAGE_HEIGHT, PADDING);

endpackage

// File: rtl/conv_line_delay.sv
// Enable-gated shift delay: dout is the sample accepted DEPTH enables ago.
// Contents are not reset; downstream gating keeps stale data from being used.
module conv_line_delay #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] taps_q [DEPTH];

    // Shift one position per accepted sample, hold otherwise
    always_ff @(posedge clk) begin
        if (en) begin
            taps_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                taps_q[i] <= taps_q[i-1];
            end
        end
    end

    // Oldest tap is the sample from one padded row earlier
    always_comb begin
        dout = taps_q[DEPTH-1];
    end

endmodule

// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator over a padded, channel-serial raster stream.
// Two row-deep line delays supply the rows above the incoming sample; a 3x3
// register shifts one column per accepted sample. A window is flagged valid
// only once the current sample is at row>=2 and col>=2 of its channel, so
// line-delay contents from a previous channel or before reset never escape.
module conv_window_gen
    import conv_pkg::padded_dim;
#(
    parameter int DATA_WIDTH   = conv_pkg::DATA_WIDTH,
    parameter int IMAGE_WIDTH  = conv_pkg::IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = conv_pkg::IMAGE_HEIGHT,
    parameter int PADDING      = conv_pkg::PADDING,
    parameter int CHANNEL_NUM  = conv_pkg::CHANNEL_NUM,
    parameter int KERNEL       = conv_pkg::KERNEL
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_in,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [9*DATA_WIDTH-1:0] win_out,
    output logic                    valid_out,
    output logic                    frame_done
);

    localparam int PW   = padded_dim(IMAGE_WIDTH, PADDING);
    localparam int PH   = padded_dim(IMAGE_HEIGHT, PADDING);
    localparam int ColW = $clog2(PW) + 1;
    localparam int RowW = $clog2(PH) + 1;
    localparam int ChW  = $clog2(CHANNEL_NUM) + 1;

    if (KERNEL != 3) begin : g_kernel_unsupported
        $error("conv_window_gen supports KERNEL=3 only");
    end

    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;
    logic [ChW-1:0]  ch_q,  ch_d;
    logic            col_last, row_last, ch_last;
    logic            win_hit, frame_hit;

    logic [DATA_WIDTH-1:0] line1_out, line2_out;
    logic [DATA_WIDTH-1:0] win_q [3][3];

    // Position decode and raster counter next state
    always_comb begin
        col_last  = (col_q == ColW'(PW - 1));
        row_last  = (row_q == RowW'(PH - 1));
        ch_last   = (ch_q == ChW'(CHANNEL_NUM - 1));
        win_hit   = valid_in && (row_q >= RowW'(2)) && (col_q >= ColW'(2));
        frame_hit = win_hit && col_last && row_last && ch_last;

        col_d = col_q;
        row_d = row_q;
        ch_d  = ch_q;
        if (valid_in) begin
            if (col_last) begin
                col_d = '0;
                if (row_last) begin
                    row_d = '0;
                    ch_d  = ch_last ? '0 : ch_q + 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Counters and output flags; reset abandons any partial frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q      <= '0;
            row_q      <= '0;
            ch_q       <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            ch_q       <= ch_d;
            valid_out  <= win_hit;
            frame_done <= frame_hit;
        end
    end

    conv_line_delay #(
        .DEPTH      (PW),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_line1 (
        .clk  (clk),
        .en   (valid_in),
        .din  (data_in),
        .dout (line1_out)
    );

    conv_line_delay #(
        .DEPTH      (PW),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_line2 (
        .clk  (clk),
        .en   (valid_in),
        .din  (line1_out),
        .dout (line2_out)
    );

    // Window shifts left; new right column is {two rows up, one row up, current}
    always_ff @(posedge clk) begin
        if (valid_in) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= line2_out;
            win_q[1][2] <= line1_out;
            win_q[2][2] <= data_in;
        end
    end

    // Flatten window: element (r,c) at slot r*3+c
    always_comb begin
        win_out = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win_out[(r*3+c)*DATA_WIDTH +: DATA_WIDTH] = win_q[r][c];
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: default 8x8x2 instance (A) and a
// 6x5x1 padded instance (B). Drivers push expected windows; monitors pop them.
module tb_conv_window_gen;

    localparam int DW = 32;
    localparam int WW = 9 * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a, vin_a, vout_a, fd_a;
    logic [DW-1:0] din_a;
    logic [WW-1:0] win_a;
    logic          rst_b, vin_b, vout_b, fd_b;
    logic [DW-1:0] din_b;
    logic [WW-1:0] win_b;

    conv_window_gen u_dut_a (
        .clk        (clk),
        .reset      (rst_a),
        .valid_in   (vin_a),
        .data_in    (din_a),
        .win_out    (win_a),
        .valid_out  (vout_a),
        .frame_done (fd_a)
    );

    conv_window_gen #(
        .DATA_WIDTH   (DW),
        .IMAGE_WIDTH  (4),
        .IMAGE_HEIGHT (3),
        .PADDING      (1),
        .CHANNEL_NUM  (1),
        .KERNEL       (3)
    ) u_dut_b (
        .clk        (clk),
        .reset      (rst_b),
        .valid_in   (vin_b),
        .data_in    (din_b),
        .win_out    (win_b),
        .valid_out  (vout_b),
        .frame_done (fd_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [WW:0]   exp_a [$];
    logic [WW:0]   exp_b [$];
    logic [WW-1:0] got_a [$];
    logic [WW-1:0] got_b [$];
    int fd_cnt_a = 0, fd_idx_a = 0, fd_cnt_b = 0, fd_idx_b = 0;
    logic vin_q_a = 1'b0, vin_q_b = 1'b0;

    task automatic chk(input string name, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [WW-1:0] pack9(input int a0, input int a1, input int a2,
                                            input int a3, input int a4, input int a5,
                                            input int a6, input int a7, input int a8);
        int v[9];
        logic [WW-1:0] w;
        v = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
        for (int i = 0; i < 9; i++) w[i*DW +: DW] = DW'(v[i]);
        return w;
    endfunction

    // Expected window ending at (row,col) when pixel = off + row*pw + col
    function automatic logic [WW-1:0] model_win(input int off, input int pw,
                                                input int row, input int col);
        logic [WW-1:0] w;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[(r*3+c)*DW +: DW] = DW'(off + (row - 2 + r) * pw + (col - 2 + c));
        return w;
    endfunction

    task automatic idle(input int n);
        vin_a = 1'b0;
        vin_b = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive up to 'limit' samples of a padded frame, pushing expectations
    task automatic run_frame(input bit sel, input int pw, input int ph, input int nch,
                             input int limit, input bit gaps, input int off0, input int off1);
        int total, ch, row, col, off;
        logic [WW:0] e;
        total = pw * ph * nch;
        if (limit < total) total = limit;
        for (int s = 0; s < total; s++) begin
            ch  = s / (pw * ph);
            row = (s / pw) % ph;
            col = s % pw;
            off = (ch == 0) ? off0 : off1;
            if (gaps && ($urandom_range(0, 1) == 1)) idle($urandom_range(1, 5));
            if (row >= 2 && col >= 2) begin
                e = {(row == ph - 1 && col == pw - 1 && ch == nch - 1), model_win(off, pw, row, col)};
                if (sel) exp_b.push_back(e);
                else exp_a.push_back(e);
            end
            if (sel) begin
                vin_b = 1'b1;
                din_b = DW'(off + row * pw + col);
            end else begin
                vin_a = 1'b1;
                din_a = DW'(off + row * pw + col);
            end
            @(posedge clk);
            #1;
            vin_a = 1'b0;
            vin_b = 1'b0;
        end
    endtask

    task automatic chk_got(input string name, input bit sel, input int idx, input logic [WW-1:0] exp);
        int n;
        n = sel ? got_b.size() : got_a.size();
        if (idx >= n) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got no window %0d (only %0d) expected %h", name, idx, n, exp);
        end else begin
            chk(name, sel ? got_b[idx] : got_a[idx], exp);
        end
    endtask

    task automatic clear_a();
        exp_a.delete();
        got_a.delete();
        fd_cnt_a = 0;
        fd_idx_a = 0;
    endtask

    always @(posedge clk) begin
        vin_q_a <= vin_a;
        vin_q_b <= vin_b;
    end

    // Monitor A: compare each presented window against the scoreboard
    always @(negedge clk) begin
        logic [WW:0] e;
        if (!rst_a) begin
            chk("a_reset_vout", WW'(vout_a), '0);
            chk("a_reset_fd", WW'(fd_a), '0);
        end else begin
            if (!vin_q_a) chk("a_gap_vout", WW'(vout_a), '0);
            if (!vout_a) begin
                chk("a_fd_without_vout", WW'(fd_a), '0);
            end else begin
                if (exp_a.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL a_unexpected_window: got %h expected none", win_a);
                end else begin
                    e = exp_a.pop_front();
                    chk("a_window", win_a, e[WW-1:0]);
                    chk("a_frame_done", WW'(fd_a), WW'(e[WW]));
                end
                got_a.push_back(win_a);
                if (fd_a) begin
                    fd_cnt_a++;
                    fd_idx_a = got_a.size();
                end
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        logic [WW:0] e;
        if (!rst_b) begin
            chk("b_reset_vout", WW'(vout_b), '0);
        end else begin
            if (!vin_q_b) chk("b_gap_vout", WW'(vout_b), '0);
            if (!vout_b) begin
                chk("b_fd_without_vout", WW'(fd_b), '0);
            end else begin
                if (exp_b.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL b_unexpected_window: got %h expected none", win_b);
                end else begin
                    e = exp_b.pop_front();
                    chk("b_window", win_b, e[WW-1:0]);
                    chk("b_frame_done", WW'(fd_b), WW'(e[WW]));
                end
                got_b.push_back(win_b);
                if (fd_b) begin
                    fd_cnt_b++;
                    fd_idx_b = got_b.size();
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WW-1:0] first0, last0, first1;
        first0 = pack9(0, 1, 2, 8, 9, 10, 16, 17, 18);
        last0  = pack9(45, 46, 47, 53, 54, 55, 61, 62, 63);
        first1 = pack9(100, 101, 102, 108, 109, 110, 116, 117, 118);

        rst_a = 1'b0; rst_b = 1'b0;
        vin_a = 1'b0; vin_b = 1'b0;
        din_a = '0;   din_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_vout_a", WW'(vout_a), '0);
        chk("reset_fd_a", WW'(fd_a), '0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        idle(2);

        // Continuous two-channel frame
        run_frame(1'b0, 8, 8, 2, 1000, 1'b0, 0, 100);
        idle(4);
        chk("p1_pending", WW'(exp_a.size()), '0);
        chk("p1_count", WW'(got_a.size()), WW'(72));
        chk_got("p1_first_ch0", 1'b0, 0, first0);
        chk_got("p1_last_ch0", 1'b0, 35, last0);
        chk_got("p1_first_ch1", 1'b0, 36, first1);
        chk("p1_fd_count", WW'(fd_cnt_a), WW'(1));
        chk("p1_fd_index", WW'(fd_idx_a), WW'(72));
        clear_a();

        // Same frame with random gaps in valid_in
        run_frame(1'b0, 8, 8, 2, 1000, 1'b1, 0, 100);
        idle(4);
        chk("p2_pending", WW'(exp_a.size()), '0);
        chk("p2_count", WW'(got_a.size()), WW'(72));
        chk_got("p2_first_ch0", 1'b0, 0, first0);
        chk_got("p2_last_ch0", 1'b0, 35, last0);
        chk("p2_fd_index", WW'(fd_idx_a), WW'(72));
        clear_a();

        // 30 samples of a stale frame, then an asynchronous mid-frame reset
        run_frame(1'b0, 8, 8, 1, 30, 1'b0, 500, 500);
        chk("p3_pre_reset_vout", WW'(vout_a), WW'(1));
        #2;
        rst_a = 1'b0;
        #1;
        chk("p3_async_reset_vout", WW'(vout_a), '0);
        chk("p3_async_reset_fd", WW'(fd_a), '0);
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b1;
        clear_a();
        idle(1);
        run_frame(1'b0, 8, 8, 2, 1000, 1'b0, 0, 100);
        idle(4);
        chk("p3_pending", WW'(exp_a.size()), '0);
        chk("p3_count", WW'(got_a.size()), WW'(72));
        chk_got("p3_first_ch0", 1'b0, 0, first0);
        chk("p3_fd_index", WW'(fd_idx_a), WW'(72));

        // Small geometry: 4x3 image, padding 1, single channel -> 6x5 padded
        run_frame(1'b1, 6, 5, 1, 1000, 1'b0, 0, 0);
        idle(4);
        chk("b_pending", WW'(exp_b.size()), '0);
        chk("b_count", WW'(got_b.size()), WW'(12));
        chk_got("b_first", 1'b1, 0, pack9(0, 1, 2, 6, 7, 8, 12, 13, 14));
        chk_got("b_last", 1'b1, 11, pack9(15, 16, 17, 21, 22, 23, 27, 28, 29));
        chk("b_fd_count", WW'(fd_cnt_b), WW'(1));
        chk("b_fd_index", WW'(fd_idx_b), WW'(12));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of one sample.
REQ-002 Parameter IMAGE_WIDTH, default 6, unpadded image width.
REQ-003 Parameter IMAGE_HEIGHT, default 6, unpadded image height.
REQ-004 Parameter PADDING, default 1, border width already inserted upstream.
REQ-005 Parameter CHANNEL_NUM, default 2, channels per frame, streamed channel-serially.
REQ-006 Parameter KERNEL, default 3; only the value 3 is supported.
REQ-007 Ports SHALL be, in order:
- clk, input, 1, sole clock, rising edge.
- reset, input, 1, asynchronous active-low reset.
- valid_in, input, 1, data_in carries one padded-stream sample this cycle.
- data_in, input, DATA_WIDTH, padded sample, raster order: row-major within a channel, channel after channel.
- win_out, output, 9*DATA_WIDTH, 3x3 window; element (r,c) at bits [(r*3+c)*DATA_WIDTH +: DATA_WIDTH], r=0 is the oldest row, c=0 the oldest column.
- valid_out, output, 1, win_out holds a complete window.
- frame_done, output, 1, one-cycle pulse on the last window of the last channel.

Function
REQ-008 PW = IMAGE_WIDTH+2*PADDING and PH = IMAGE_HEIGHT+2*PADDING SHALL define the padded geometry (8x8 by default).
REQ-009 Counters col (0..PW-1), row (0..PH-1) and ch (0..CHANNEL_NUM-1) SHALL advance only on cycles with valid_in=1; counter widths are $clog2(max)+1.
REQ-010 When col=PW-1, col SHALL wrap to 0 and row SHALL increment; when row=PH-1 as well, row SHALL wrap to 0 and ch SHALL increment; when ch=CHANNEL_NUM-1 as well, ch SHALL wrap to 0.
REQ-011 Two line delays of depth PW SHALL hold the previous two padded rows; each shifts only on valid_in.
REQ-012 The 3x3 window register SHALL shift left by one column on each accepted sample, taking the new right column {line2_out, line1_out, data_in} for rows 0..2.
REQ-013 valid_out SHALL be asserted exactly one cycle after an accepted sample with row>=2 and col>=2, and SHALL be 0 otherwise.
REQ-014 Each channel SHALL produce (PH-2)*(PW-2) windows (36 by default), with stride 1 and no windows spanning a row or channel boundary.
REQ-015 frame_done SHALL be asserted in the same cycle as the valid_out for the sample at row=PH-1, col=PW-1, ch=CHANNEL_NUM-1.
REQ-016 Gaps in valid_in of any length SHALL freeze all counters, line delays and the window register; valid_out SHALL drop to 0 during a gap.
REQ-017 There SHALL be no backpressure; every accepted sample is consumed.
REQ-018 Channel and frame boundaries SHALL need no idle cycle; a sample for row 0 of the next channel may follow the last sample of a channel back-to-back.
REQ-019 The first two rows of a new channel SHALL overwrite the line delays; no window of the new channel SHALL contain data from the previous channel.

Reset
REQ-020 While reset=0, valid_out, frame_done, col, row and ch SHALL be 0, independent of clk.
REQ-021 Line-delay and window contents SHALL be don't-care after reset; REQ-013 gating ensures that stale data is never flagged valid.
REQ-022 Reset asserted mid-frame SHALL abandon the frame; the next accepted sample SHALL be treated as row 0, col 0, ch 0.

Structure
REQ-023 Shared package conv_pkg SHALL hold the default geometry constants (DATA_WIDTH, IMAGE_WIDTH, IMAGE_HEIGHT, PADDING, CHANNEL_NUM) and the PW/PH derivations, shared with the padding stage.
REQ-024 Sub-module conv_line_delay SHALL be a parameterised (DEPTH, DATA_WIDTH) enable-gated shift delay, instantiated twice.

Verification
REQ-025 Defaults, continuous valid_in, ch0 sample = row*8+col: first valid_out on the cycle after sample 18, with win_out (r0..r2) = {0,1,2 / 8,9,10 / 16,17,18}.
REQ-026 Same stream: exactly 36 valid_out pulses per channel; the last window of ch0 = {45,46,47 / 53,54,55 / 61,62,63}.
REQ-027 Two channels back-to-back, ch1 sample = 100+row*8+col: the first ch1 window = {100,101,102 / 108,109,110 / 116,117,118}; frame_done pulses exactly once, with the 72nd window.
REQ-028 Random valid_in gaps (1-5 cycles, 50% duty): the window sequence is identical to REQ-025/026, and valid_out never asserts during a gap.
REQ-029 Reset pulled low after 30 samples, then a full frame: valid_out=0 within the reset window, and the output matches REQ-025 exactly, with no stale windows.
REQ-030 IMAGE_WIDTH=4, IMAGE_HEIGHT=3, PADDING=1, CHANNEL_NUM=1: 12 windows, frame_done with the 12th.
